// File: rtl/word_hash_frontend.sv
// Byte-stream word splitter and dual hasher that drives a Bloom filter.
// Each completed word is issued once (insert in learn mode, lookup otherwise) and its result is reported.
module word_hash_frontend #(
    parameter int         MAX_WORD_LEN = 32,
    parameter logic [7:0] H1_INIT      = 8'h00,
    parameter logic [7:0] H2_INIT      = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        learn,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        bf_enable,
    output logic        bf_write,
    output logic        bf_check,
    output logic [7:0]  bf_hash1,
    output logic [7:0]  bf_hash2,
    input  logic        bf_word_detected,
    output logic        word_valid,
    output logic        word_hit,
    output logic [5:0]  word_len,
    output logic [15:0] word_count
);

    localparam logic [5:0] MAX_LEN = 6'(MAX_WORD_LEN);

    typedef enum logic [1:0] {ACCUM, ISSUE, WAIT} state_t;

    state_t     state;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [5:0] len;
    logic       mode;

    logic       accept;
    logic       is_upper;
    logic       is_letter;
    logic [7:0] c;
    logic       hashing;
    logic       close;
    logic [7:0] h1_next;
    logic [7:0] h2_next;
    logic [5:0] len_next;
    logic       mode_next;

    function automatic logic [7:0] hash1_step(input logic [7:0] h, input logic [7:0] ch);
        logic [7:0] h_x32;
        h_x32 = {h[2:0], 5'b00000};
        return h_x32 + h + ch;
    endfunction

    function automatic logic [7:0] hash2_step(input logic [7:0] h, input logic [7:0] ch);
        return {h[4:0], h[7:5]} ^ ch;
    endfunction

    always_comb begin
        accept    = s_valid & s_ready;
        is_upper  = (s_data >= 8'h41) && (s_data <= 8'h5A);
        is_letter = is_upper || ((s_data >= 8'h61) && (s_data <= 8'h7A));
        c         = is_upper ? (s_data | 8'h20) : s_data;
        hashing   = is_letter && (len < MAX_LEN);
        h1_next   = hashing ? hash1_step(h1, c) : h1;
        h2_next   = hashing ? hash2_step(h2, c) : h2;
        len_next  = hashing ? len + 6'd1 : len;
        // Mode is captured only on a word's first letter so mid-word toggles are ignored.
        mode_next = (is_letter && (len == 6'd0)) ? learn : mode;
        close     = s_last || !is_letter;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ACCUM;
            h1         <= H1_INIT;
            h2         <= H2_INIT;
            len        <= 6'd0;
            mode       <= 1'b0;
            s_ready    <= 1'b1;
            bf_enable  <= 1'b0;
            bf_write   <= 1'b0;
            bf_check   <= 1'b0;
            bf_hash1   <= 8'h00;
            bf_hash2   <= 8'h00;
            word_valid <= 1'b0;
            word_hit   <= 1'b0;
            word_len   <= 6'd0;
            word_count <= 16'd0;
        end else begin
            word_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (accept) begin
                        h1   <= h1_next;
                        h2   <= h2_next;
                        len  <= len_next;
                        mode <= mode_next;
                        // A closing byte only ends a word if at least one letter was seen.
                        if (close && (len_next != 6'd0)) begin
                            state     <= ISSUE;
                            s_ready   <= 1'b0;
                            bf_enable <= 1'b1;
                            bf_write  <= mode_next;
                            bf_check  <= ~mode_next;
                            bf_hash1  <= h1_next;
                            bf_hash2  <= h2_next;
                        end
                    end
                end
                ISSUE: begin
                    bf_enable <= 1'b0;
                    bf_write  <= 1'b0;
                    bf_check  <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    word_valid <= 1'b1;
                    word_hit   <= ~mode & bf_word_detected;
                    word_len   <= len;
                    word_count <= word_count + 16'd1;
                    h1         <= H1_INIT;
                    h2         <= H2_INIT;
                    len        <= 6'd0;
                    s_ready    <= 1'b1;
                    state      <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_word_hash_frontend.sv
// Directed bench for word_hash_frontend: a vector table of single words plus
// hand-written sequences for long words, back-to-back streaming and reset during WAIT.
module tb_word_hash_frontend;

    logic        clock = 1'b0;
    logic        reset;
    logic        learn;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        bf_enable;
    logic        bf_write;
    logic        bf_check;
    logic [7:0]  bf_hash1;
    logic [7:0]  bf_hash2;
    logic        bf_word_detected = 1'b0;
    logic        word_valid;
    logic        word_hit;
    logic [5:0]  word_len;
    logic [15:0] word_count;

    word_hash_frontend dut (
        .clock(clock), .reset(reset), .learn(learn),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .bf_enable(bf_enable), .bf_write(bf_write), .bf_check(bf_check),
        .bf_hash1(bf_hash1), .bf_hash2(bf_hash2), .bf_word_detected(bf_word_detected),
        .word_valid(word_valid), .word_hit(word_hit), .word_len(word_len),
        .word_count(word_count)
    );

    always #5 clock = ~clock;

    int  checks = 0;
    int  errors = 0;
    bit  resp   = 1'b0;

    // Filter stand-in: registered answer one cycle after a check request.
    always @(posedge clock) bf_word_detected <= bf_enable & bf_check & resp;

    int         n_issue = 0, n_wv = 0, ready_low = 0, proto_err = 0, bytes_acc = 0;
    logic [7:0] iss_h1, iss_h2;
    logic       iss_wr, iss_ck;
    time        wv_time, acc_time;

    always @(negedge clock) begin
        if (!reset) begin
            if (bf_enable) begin
                n_issue++;
                iss_h1 = bf_hash1; iss_h2 = bf_hash2;
                iss_wr = bf_write; iss_ck = bf_check;
            end
            if ((bf_write && bf_check) || (!bf_enable && (bf_write || bf_check))) proto_err++;
            if (word_valid) begin
                n_wv++;
                wv_time = $time;
            end
            if (!s_ready) ready_low++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit lrn);
        int tries = 0;
        @(negedge clock);
        s_data = b; s_last = last; s_valid = 1'b1; learn = lrn;
        while (!s_ready) begin
            tries++;
            if (tries > 20) begin
                checks++; errors++;
                $display("FAIL s_ready_timeout: got 0 expected 1");
                break;
            end
            @(negedge clock);
        end
        acc_time = $time;
        @(posedge clock);
        bytes_acc++;
    endtask

    task automatic send_str(input string txt, input bit last, input bit lrn, input bit tog);
        for (int i = 0; i < txt.len(); i++)
            send_byte(txt[i], last && (i == txt.len() - 1), (tog && i > 0) ? ~lrn : lrn);
        @(negedge clock);
        s_valid = 1'b0; s_last = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    function automatic void model(input string w, output logic [7:0] a, output logic [7:0] b);
        int n = 0;
        logic [7:0] ch;
        a = 8'h00; b = 8'hA5;
        for (int i = 0; i < w.len(); i++) begin
            ch = w[i];
            if (ch >= 8'h41 && ch <= 8'h5A) ch = ch + 8'h20;
            if (n < 32) begin
                a = a * 8'd33 + ch;
                b = {b[4:0], b[7:5]} ^ ch;
                n++;
            end
        end
    endfunction

    typedef struct {
        string      txt;
        bit         last;
        bit         lrn;
        bit         tog;
        bit         resp;
        bit         exp_wr;
        logic [7:0] exp_h1;
        logic [7:0] exp_h2;
        logic [5:0] exp_len;
        bit         exp_hit;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int issue0, wv0, rl0, ba0;
        logic [7:0] mh1, mh2;
        string long_w;

        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int issue0, wv0, rl0, ba0;
        logic [7:0] mh1, mh2;
        string long_w;

        vecs[0] = '{"ab ",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE3, 8'h00, 6'd1 + 6'd1, 1'b0};
        vecs[1] = '{"AB.",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE3, 8'h00, 6'd2, 1'b1};
        vecs[2] = '{"  ,,x", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78, 8'h55, 6'd1, 1'b0};
        vecs[3] = '{"Hi!",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hD1, 8'h43, 6'd2, 1'b0};
        vecs[4] = '{"z9",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7A, 8'h57, 6'd1, 1'b0};
        vecs[5] = '{"cd ",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h27, 8'h16, 6'd2, 1'b1};

        reset = 1'b1; learn = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_bf_enable", bf_enable, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_word_len", word_len, 0);

        for (int v = 0; v < 6; v++) begin
            issue0 = n_issue; wv0 = n_wv; rl0 = ready_low;
            resp = vecs[v].resp;
            send_str(vecs[v].txt, vecs[v].last, vecs[v].lrn, vecs[v].tog);
            chk($sformatf("v%0d_issues", v), n_issue - issue0, 1);
            chk($sformatf("v%0d_write", v), iss_wr, vecs[v].exp_wr);
            chk($sformatf("v%0d_check", v), iss_ck, !vecs[v].exp_wr);
            chk($sformatf("v%0d_hash1", v), iss_h1, vecs[v].exp_h1);
            chk($sformatf("v%0d_hash2", v), iss_h2, vecs[v].exp_h2);
            chk($sformatf("v%0d_words", v), n_wv - wv0, 1);
            chk($sformatf("v%0d_latency", v), 32'(wv_time - acc_time), 30);
            chk($sformatf("v%0d_len", v), word_len, vecs[v].exp_len);
            chk($sformatf("v%0d_hit", v), word_hit, vecs[v].exp_hit);
            chk($sformatf("v%0d_count", v), word_count, v + 1);
            chk($sformatf("v%0d_ready_gap", v), ready_low - rl0, 2);
        end

        // 40-letter word: only the first 32 letters are hashed and counted.
        long_w = "";
        for (int i = 0; i < 40; i++)
            long_w = {long_w, string'((i % 3 == 0) ? 8'h41 + 8'(i % 26) : 8'h61 + 8'(i % 26))};
        model(long_w.substr(0, 31), mh1, mh2);
        issue0 = n_issue; wv0 = n_wv; rl0 = ready_low; resp = 1'b0;
        send_str({long_w, " "}, 1'b0, 1'b0, 1'b0);
        chk("long_issues", n_issue - issue0, 1);
        chk("long_hash1", iss_h1, mh1);
        chk("long_hash2", iss_h2, mh2);
        chk("long_len", word_len, 32);
        chk("long_ready_gap", ready_low - rl0, 2);

        // Continuous s_valid over three one-letter words.
        wv0 = n_wv; rl0 = ready_low; ba0 = bytes_acc;
        send_str("a b c ", 1'b0, 1'b1, 1'b0);
        chk("stream_words", n_wv - wv0, 3);
        chk("stream_ready_gap", ready_low - rl0, 6);
        chk("stream_bytes", bytes_acc - ba0, 6);
        chk("stream_count", word_count, 10);
        chk("stream_len", word_len, 1);

        // Reset while the word is in WAIT: nothing may complete.
        send_byte(8'h61, 1'b0, 1'b0);
        send_byte(8'h62, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        @(negedge clock);
        s_valid = 1'b0;
        chk("rw_issue_seen", bf_enable, 1);
        @(negedge clock);
        wv0 = n_wv;
        reset = 1'b1;
        @(negedge clock);
        chk("rw_s_ready", s_ready, 1);
        chk("rw_word_valid", word_valid, 0);
        chk("rw_word_count", word_count, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("rw_no_word", n_wv - wv0, 0);
        send_str("q ", 1'b0, 1'b1, 1'b0);
        chk("rw_after_count", word_count, 1);
        chk("rw_after_len", word_len, 1);

        chk("bf_exclusive", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
